// File: rtl/bb_mem_responder_pkg.sv
// Shared types for the black_bean memory responder: core action codes,
// responder FSM states and the saturating fetch-counter helper.
package bb_mem_responder_pkg;

   localparam int DATA_WIDTH_DEF = 16;
   localparam int ADDR_BITS_DEF  = 8;
   localparam int FETCH_CNT_W    = 16;

   // Action codes are shared with the core's decoder; keep encodings in sync.
   typedef enum logic [1:0] {
      MEM_NOP   = 2'b00,
      MEM_READ  = 2'b01,
      MEM_WRITE = 2'b10,
      MEM_FETCH = 2'b11
   } mem_action_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_LOAD = 2'b01,
      ST_RUN  = 2'b10,
      ST_HALT = 2'b11
   } resp_state_e;

   function automatic logic [FETCH_CNT_W-1:0] sat_inc(input logic [FETCH_CNT_W-1:0] v);
      return (&v) ? v : v + {{(FETCH_CNT_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/bb_sram.sv
// Single-port synchronous RAM with a registered read port. The read register
// only loads on read cycles, so it holds its value across writes and idle cycles.
module bb_sram #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_BITS  = 8
) (
   input  logic                  clk,
   input  logic                  en_i,
   input  logic                  we_i,
   input  logic [ADDR_BITS-1:0]  addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [2**ADDR_BITS];
   logic [DATA_WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (en_i) begin
         if (we_i) begin
            mem_q[addr_i] <= wdata_i;
         end else begin
            rdata_q <= mem_q[addr_i];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/bb_mem_responder.sv
// Memory-side responder for bb_core: owns program loading, core hold/halt
// control and the RAM port mux between the loader and the running core.
module bb_mem_responder
   import bb_mem_responder_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_BITS  = ADDR_BITS_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [1:0]             i_action,
   input  logic [DATA_WIDTH-1:0]  i_addr,
   input  logic [DATA_WIDTH-1:0]  i_data,
   output logic [DATA_WIDTH-1:0]  o_data,
   input  logic                   i_load_valid,
   input  logic [ADDR_BITS-1:0]   i_load_addr,
   input  logic [DATA_WIDTH-1:0]  i_load_data,
   output logic                   o_load_ready,
   input  logic                   i_load_done,
   input  logic                   i_restart,
   output logic                   o_core_hold,
   output logic                   o_halted,
   output logic                   o_addr_err,
   output logic [FETCH_CNT_W-1:0] o_fetch_cnt
);

   localparam logic [DATA_WIDTH-1:0] HALT_ADDR = '1;

   resp_state_e            state_q, state_d;
   logic                   zero_q, zero_d;
   logic                   err_q, err_d;
   logic [FETCH_CNT_W-1:0] cnt_q, cnt_d;

   logic                   ram_en, ram_we;
   logic [ADDR_BITS-1:0]   ram_addr;
   logic [DATA_WIDTH-1:0]  ram_wdata, ram_rdata;

   logic                   in_range;
   logic                   is_halt;
   mem_action_e            action;

   assign action  = mem_action_e'(i_action);
   assign is_halt = (i_addr == HALT_ADDR);

   generate
      if (ADDR_BITS < DATA_WIDTH) begin : g_range_chk
         assign in_range = ~|i_addr[DATA_WIDTH-1:ADDR_BITS];
      end else begin : g_range_all
         assign in_range = 1'b1;
      end
   endgenerate

   always_comb begin
      state_d   = state_q;
      zero_d    = zero_q;
      err_d     = err_q;
      cnt_d     = cnt_q;
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = i_load_addr;
      ram_wdata = i_load_data;

      case (state_q)
         ST_IDLE: begin
            state_d = ST_LOAD;
         end
         ST_LOAD: begin
            ram_en = i_load_valid;
            ram_we = i_load_valid;
            if (i_load_done) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end
         end
         ST_RUN: begin
            ram_addr  = i_addr[ADDR_BITS-1:0];
            ram_wdata = i_data;
            case (action)
               MEM_READ, MEM_FETCH: begin
                  if (action == MEM_FETCH) begin
                     cnt_d = sat_inc(cnt_q);
                  end
                  // zero_d selects a forced-zero response without disturbing the RAM read register
                  if (in_range) begin
                     ram_en = 1'b1;
                     zero_d = 1'b0;
                  end else begin
                     zero_d = 1'b1;
                     err_d  = 1'b1;
                  end
               end
               MEM_WRITE: begin
                  if (is_halt) begin
                     state_d = ST_HALT;
                  end else if (in_range) begin
                     ram_en = 1'b1;
                     ram_we = 1'b1;
                  end else begin
                     err_d = 1'b1;
                  end
               end
               default: ;
            endcase
         end
         ST_HALT: begin
            if (i_restart) begin
               state_d = ST_LOAD;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         zero_q  <= 1'b1;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         zero_q  <= zero_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   bb_sram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_BITS  (ADDR_BITS)
   ) u_sram (
      .clk     (clk),
      .en_i    (ram_en),
      .we_i    (ram_we),
      .addr_i  (ram_addr),
      .wdata_i (ram_wdata),
      .rdata_o (ram_rdata)
   );

   assign o_data       = zero_q ? '0 : ram_rdata;
   assign o_load_ready = (state_q == ST_LOAD);
   assign o_core_hold  = (state_q != ST_RUN);
   assign o_halted     = (state_q == ST_HALT);
   assign o_addr_err   = err_q;
   assign o_fetch_cnt  = cnt_q;

endmodule
